fir_delay_line_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the single-port 128x18 block RAM (mem_example) and drives its ce/oce/wre/adr/din pins.
- Stores each incoming sample in a circular buffer inside the RAM.
- Reads the most recent NTAPS samples back, newest first, and presents them with a tap index to the downstream FIR MAC.
- Zero-masks taps that have not yet been written since reset.

---
 rtl/dsp_pkg.sv | 19 +
 rtl/fir_lat_pipe.sv | 30 +++
 rtl/fir_delay_line_ctrl.sv | 155 +++++++++++++++
 tb/tb_fir_delay_line_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP types and defaults for the FIR front end.
// Holds the delay-line FSM states and a tap-index width helper.
package dsp_pkg;

   localparam int DW_DEF = 18;
   localparam int AW_DEF = 7;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN
   } dl_state_t;

   function automatic int tap_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_lat_pipe.sv
// Fixed-depth shift register that lines tap control up with RAM data.
// Depth equals the RAM read latency.
module fir_lat_pipe #(
   parameter int W     = 4,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stg [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/fir_delay_line_ctrl.sv
// Circular-buffer sequencer for a single-port RAM feeding a FIR MAC.
// Writes one sample, then streams the newest NTAPS samples back.
module fir_delay_line_ctrl
   import dsp_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NTAPS    = 16,
   parameter int READ_LAT = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DW-1:0]             s_data,
   output logic                      m_valid,
   output logic [DW-1:0]             m_data,
   output logic [tap_w(NTAPS)-1:0]   m_tap,
   output logic                      m_last,
   output logic                      mem_ce,
   output logic                      mem_oce,
   output logic                      mem_wre,
   output logic [AW-1:0]             mem_adr,
   output logic [DW-1:0]             mem_din,
   input  logic [DW-1:0]             mem_dout
);

   localparam int TW = tap_w(NTAPS);
   localparam int CW = $clog2(NTAPS + READ_LAT + 1);
   localparam int PW = TW + 3;

   dl_state_t      state, state_n;
   logic [AW-1:0]  head, head_n;
   logic [CW-1:0]  fill, fill_n;
   logic [CW-1:0]  k, k_n;

   logic           ce_n, oce_n, wre_n;
   logic [AW-1:0]  adr_n;
   logic [DW-1:0]  din_n;

   logic           rd_vld, rd_vld_n;
   logic [TW-1:0]  rd_tap, rd_tap_n;
   logic           rd_last, rd_last_n;
   logic           rd_mask, rd_mask_n;

   logic [PW-1:0]  pipe_q;
   logic           p_mask;

   assign s_ready = (state == IDLE);

   always_comb begin
      state_n = state;
      head_n  = head;
      fill_n  = fill;
      k_n     = k;
      unique case (state)
         IDLE: begin
            if (s_valid) begin
               state_n = WRITE;
               k_n     = '0;
            end
         end
         WRITE: begin
            fill_n  = (fill == CW'(NTAPS)) ? fill : fill + 1'b1;
            state_n = READ;
            k_n     = '0;
         end
         READ: begin
            if (k == CW'(NTAPS - 1)) begin
               state_n = DRAIN;
               k_n     = '0;
            end else begin
               k_n = k + 1'b1;
            end
         end
         DRAIN: begin
            if (k == CW'(READ_LAT - 1)) begin
               state_n = IDLE;
               head_n  = head + 1'b1;
               k_n     = '0;
            end else begin
               k_n = k + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from next-state so the pins switch with the state.
   always_comb begin
      ce_n      = (state_n != IDLE);
      wre_n     = (state_n == WRITE);
      oce_n     = (state_n == READ) || (state_n == DRAIN);
      adr_n     = mem_adr;
      din_n     = mem_din;
      if (state_n == WRITE) begin
         adr_n = head_n;
         din_n = s_data;
      end else if (state_n == READ) begin
         adr_n = head_n - AW'(k_n);
      end
      rd_vld_n  = (state_n == READ);
      rd_tap_n  = TW'(k_n);
      rd_last_n = rd_vld_n && (k_n == CW'(NTAPS - 1));
      rd_mask_n = rd_vld_n && (k_n < fill_n);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         head    <= '0;
         fill    <= '0;
         k       <= '0;
         mem_ce  <= 1'b0;
         mem_oce <= 1'b0;
         mem_wre <= 1'b0;
         mem_adr <= '0;
         mem_din <= '0;
         rd_vld  <= 1'b0;
         rd_tap  <= '0;
         rd_last <= 1'b0;
         rd_mask <= 1'b0;
      end else begin
         state   <= state_n;
         head    <= head_n;
         fill    <= fill_n;
         k       <= k_n;
         mem_ce  <= ce_n;
         mem_oce <= oce_n;
         mem_wre <= wre_n;
         mem_adr <= adr_n;
         mem_din <= din_n;
         rd_vld  <= rd_vld_n;
         rd_tap  <= rd_tap_n;
         rd_last <= rd_last_n;
         rd_mask <= rd_mask_n;
      end
   end

   fir_lat_pipe #(
      .W     (PW),
      .DEPTH (READ_LAT)
   ) u_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .d       ({rd_vld, rd_tap, rd_last, rd_mask}),
      .q       (pipe_q)
   );

   assign {m_valid, m_tap, m_last, p_mask} = pipe_q;

   // RAM data arrives in the same cycle as the aligned mask; gate it here.
   assign m_data = p_mask ? mem_dout : '0;

endmodule

// File: tb/tb_fir_delay_line_ctrl.sv
// Bench for fir_delay_line_ctrl: history-based model plus directed checks.
// Two builds: NTAPS=4 with READ_LAT=2 and READ_LAT=1.
module tb_fir_delay_line_ctrl;

   localparam int DW = 18;
   localparam int AW = 7;
   localparam int NT = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          s_valid, s_ready, m_valid, m_last;
   logic          mem_ce, mem_oce, mem_wre;
   logic [DW-1:0] s_data, m_data, mem_din, mem_dout;
   logic [1:0]    m_tap;
   logic [AW-1:0] mem_adr;

   logic          s_valid1, s_ready1, m_valid1, m_last1;
   logic          mem_ce1, mem_oce1, mem_wre1;
   logic [DW-1:0] s_data1, m_data1, mem_din1, mem_dout1;
   logic [1:0]    m_tap1;
   logic [AW-1:0] mem_adr1;

   fir_delay_line_ctrl #(.DW(DW), .AW(AW), .NTAPS(NT), .READ_LAT(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_data(m_data), .m_tap(m_tap), .m_last(m_last),
      .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
      .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   fir_delay_line_ctrl #(.DW(DW), .AW(AW), .NTAPS(NT), .READ_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
      .m_valid(m_valid1), .m_data(m_data1), .m_tap(m_tap1), .m_last(m_last1),
      .mem_ce(mem_ce1), .mem_oce(mem_oce1), .mem_wre(mem_wre1),
      .mem_adr(mem_adr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
   );

   // RAM models preloaded with garbage so masking is visible.
   logic [DW-1:0] ram  [128];
   logic [DW-1:0] ram1 [128];
   logic [DW-1:0] ram_r;

   initial begin
      for (int i = 0; i < 128; i++) begin
         ram[i]  = 18'h2AAAA;
         ram1[i] = 18'h15555;
      end
   end

   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_wre) ram[mem_adr] <= mem_din;
         else         ram_r <= ram[mem_adr];
         if (mem_oce) mem_dout <= ram_r;
      end
   end

   always @(posedge clk) begin
      if (mem_ce1) begin
         if (mem_wre1) ram1[mem_adr1] <= mem_din1;
         else          mem_dout1 <= ram1[mem_adr1];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Model: accepted history and the cycles each event must appear on.
   typedef struct {int c; int tap; logic [DW-1:0] d;} mev_t;
   typedef struct {int c; logic w; logic [AW-1:0] a; logic [DW-1:0] d;} aev_t;
   mev_t          mq [$];
   aev_t          aq [$];
   logic [DW-1:0] hist [$];
   int            nacc = 0;
   int            free_at = 0;
   int            mh, mf;

   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete();
         aq.delete();
         hist.delete();
         nacc    = 0;
         free_at = 0;
      end else begin
         chk("s_ready", {31'd0, s_ready}, {31'd0, cyc >= free_at});
         if (mq.size() > 0 && mq[0].c == cyc) begin
            chk("m_valid", {31'd0, m_valid}, 32'd1);
            chk("m_tap", {30'd0, m_tap}, mq[0].tap);
            chk("m_data", {14'd0, m_data}, {14'd0, mq[0].d});
            chk("m_last", {31'd0, m_last}, {31'd0, mq[0].tap == NT - 1});
            void'(mq.pop_front());
         end else begin
            chk("m_valid_idle", {31'd0, m_valid}, 32'd0);
         end
         if (aq.size() > 0 && aq[0].c == cyc) begin
            chk("mem_ce", {31'd0, mem_ce}, 32'd1);
            chk("mem_wre", {31'd0, mem_wre}, {31'd0, aq[0].w});
            chk("mem_oce", {31'd0, mem_oce}, {31'd0, !aq[0].w});
            chk("mem_adr", {25'd0, mem_adr}, {25'd0, aq[0].a});
            if (aq[0].w) chk("mem_din", {14'd0, mem_din}, {14'd0, aq[0].d});
            void'(aq.pop_front());
         end else begin
            chk("mem_wre_idle", {31'd0, mem_wre}, 32'd0);
         end
         if (s_valid && s_ready) begin
            hist.push_back(s_data);
            nacc++;
            mh = (nacc - 1) % 128;
            mf = (nacc < NT) ? nacc : NT;
            aq.push_back('{cyc + 1, 1'b1, AW'(mh), s_data});
            for (int k = 0; k < NT; k++) begin
               aq.push_back('{cyc + 2 + k, 1'b0, AW'(mh - k), DW'(0)});
               mq.push_back('{cyc + 4 + k, k,
                              (k < mf) ? hist[nacc - 1 - k] : DW'(0)});
            end
            free_at = cyc + NT + 4;
         end
      end
   end

   // Capture logs for the literal checks.
   logic [DW-1:0] seq [4];
   logic [AW-1:0] radr [4];
   logic [AW-1:0] wadr;
   int            nwr = 0;
   int            ri = 4;

   always @(negedge clk) begin
      if (m_valid) seq[m_tap] = m_data;
      if (mem_ce && mem_wre) begin
         wadr = mem_adr;
         nwr++;
         ri = 0;
      end else if (mem_ce && mem_oce && ri < 4) begin
         radr[ri] = mem_adr;
         ri++;
      end
   end

   int            rd1_c = -1;
   int            mv1_c = -1;
   int            acc1 [$];
   logic [DW-1:0] seq1 [4];

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_ce1 && mem_oce1 && !mem_wre1 && rd1_c < 0) rd1_c = cyc;
         if (m_valid1 && mv1_c < 0) mv1_c = cyc;
         if (m_valid1) seq1[m_tap1] = m_data1;
         if (s_valid1 && s_ready1) acc1.push_back(cyc);
      end
   end

   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      while (!s_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_ready stuck 0 for sample %0h", d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_seq(input string name, input int e0, input int e1,
                            input int e2, input int e3);
      chk({name, "_t0"}, {14'd0, seq[0]}, e0);
      chk({name, "_t1"}, {14'd0, seq[1]}, e1);
      chk({name, "_t2"}, {14'd0, seq[2]}, e2);
      chk({name, "_t3"}, {14'd0, seq[3]}, e3);
   endtask

   task automatic check_radr(input string name);
      chk({name, "_ra0"}, {25'd0, radr[0]}, 32'd0);
      chk({name, "_ra1"}, {25'd0, radr[1]}, 32'd127);
      chk({name, "_ra2"}, {25'd0, radr[2]}, 32'd126);
      chk({name, "_ra3"}, {25'd0, radr[3]}, 32'd125);
   endtask

   task automatic idle_wait();
      s_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   int n0;

   initial begin
      s_valid  = 1'b0;
      s_data   = '0;
      s_valid1 = 1'b0;
      s_data1  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
      chk("rst_mem_wre", {31'd0, mem_wre}, 32'd0);
      chk("rst_mem_oce", {31'd0, mem_oce}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      send(18'h00005);
      idle_wait();
      check_seq("single", 5, 0, 0, 0);
      check_radr("single");
      chk("single_wadr", {25'd0, wadr}, 32'd0);
      chk("single_nwr", nwr, 32'd1);

      s_valid1 = 1'b1;
      s_data1  = 18'd1;
      for (int n = 0; n < 40 && acc1.size() < 1; n++) begin
         @(posedge clk);
         #1;
      end
      s_data1 = 18'd2;
      for (int n = 0; n < 40 && acc1.size() < 2; n++) begin
         @(posedge clk);
         #1;
      end
      s_valid1 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("lat1_accepts", acc1.size(), 32'd2);
      if (acc1.size() >= 2) chk("lat1_period", acc1[1] - acc1[0], 32'd7);
      chk("lat1_mv_lag", mv1_c - rd1_c, 32'd1);
      chk("lat1_t0", {14'd0, seq1[0]}, 32'd2);
      chk("lat1_t1", {14'd0, seq1[1]}, 32'd1);
      chk("lat1_t2", {14'd0, seq1[2]}, 32'd0);
      chk("lat1_t3", {14'd0, seq1[3]}, 32'd0);

      for (int i = 1; i <= 5; i++) send(DW'(i));
      idle_wait();
      check_seq("b2b", 5, 4, 3, 2);
      chk("b2b_nwr", nwr, 32'd6);

      n0 = nwr;
      send(18'd9);
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = 18'd10;
      @(posedge clk);
      #1;
      chk("busy_no_write", nwr, n0 + 1);
      send(18'd10);
      idle_wait();
      chk("busy_nwr", nwr, n0 + 2);
      check_seq("busy", 10, 9, 5, 4);

      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i <= 128; i++) send(DW'(i));
      idle_wait();
      chk("wrap_wadr", {25'd0, wadr}, 32'd0);
      check_seq("wrap", 128, 127, 126, 125);
      check_radr("wrap");

      send(18'd50);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("arst_mem_ce", {31'd0, mem_ce}, 32'd0);
      chk("arst_mem_wre", {31'd0, mem_wre}, 32'd0);
      chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send(18'd7);
      idle_wait();
      check_seq("after_rst", 7, 0, 0, 0);
      chk("after_rst_wadr", {25'd0, wadr}, 32'd0);
      check_radr("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
